relu_output_stager: RTL and testbench

RELU_OUTPUT_STAGER -- requirements
Module: relu_output_stager

---
 rtl/relu_output_stager.sv | 126 ++++++++++++
 tb/tb_relu_output_stager.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/relu_output_stager.sv
// Double-buffered ReLU output stager: fill bank collects node writes, present bank drives Layer 2.
// Latency: the edge that samples layerDone in EMPTY loads the present bank and raises outputsReady.
// Backpressure: four-phase ready/ack to Layer 2; a commit during a handshake is held pending and stalls writes.

`ifndef RELU_NODES
`define RELU_NODES 4
`endif
`ifndef LAYER_2_IN_BIT_WIDTH
`define LAYER_2_IN_BIT_WIDTH 8
`endif
`ifndef RELU_INDEX_WIDTH
`define RELU_INDEX_WIDTH 3
`endif

module relu_output_stager #(
   parameter int RELU_NODES  = `RELU_NODES,
   parameter int VALUE_WIDTH = `LAYER_2_IN_BIT_WIDTH,
   parameter int INDEX_WIDTH = `RELU_INDEX_WIDTH
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              nodeWriteEnable,
   input  logic [INDEX_WIDTH-1:0]            nodeIndex,
   input  logic [VALUE_WIDTH-1:0]            nodeValue,
   input  logic                              layerDone,
   output logic                              stagerBusy,
   output logic                              outputsReady,
   input  logic                              inputsRecieved,
   output logic [RELU_NODES*VALUE_WIDTH-1:0] layer2Input,
   output logic [7:0]                        layersSent
);

   localparam int BANK_WIDTH = RELU_NODES * VALUE_WIDTH;

   localparam logic [1:0] EMPTY   = 2'd0;
   localparam logic [1:0] PRESENT = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   logic [1:0]            state;
   logic                  pending;
   logic                  ackArmed;
   logic [BANK_WIDTH-1:0] fillBank;
   logic [BANK_WIDTH-1:0] presentBank;
   logic [BANK_WIDTH-1:0] fillNext;
   logic                  writeAccept;
   logic                  commitNow;
   logic                  ackTaken;

   // Out-of-range indices and writes while a commit is pending never touch the fill bank.
   assign writeAccept = nodeWriteEnable && !pending && (int'(nodeIndex) < RELU_NODES);

   // A commit happens only from EMPTY; a pending commit takes precedence over a fresh layerDone.
   assign commitNow = (state == EMPTY) && (pending || layerDone);

   // An ack counts only if it was seen low since the last accepted ack, so an ack
   // left high across reset cannot retire a layer it never saw.
   assign ackTaken = (state == PRESENT) && inputsRecieved && ackArmed;

   assign outputsReady = (state == PRESENT);
   assign stagerBusy   = pending;
   assign layer2Input  = presentBank;

   // Fill bank as it would look after this cycle's write, so a same-cycle write joins the commit.
   always_comb begin
      fillNext = fillBank;
      for (int i = 0; i < RELU_NODES; i++) begin
         if (writeAccept && (nodeIndex == INDEX_WIDTH'(i))) begin
            fillNext[i*VALUE_WIDTH +: VALUE_WIDTH] = nodeValue;
         end
      end
   end

   // Handshake FSM, bank swap, pending-commit tracking and acknowledged-layer count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= EMPTY;
         pending     <= 1'b0;
         ackArmed    <= 1'b0;
         fillBank    <= '0;
         presentBank <= '0;
         layersSent  <= 8'd0;
      end else begin
         if (!inputsRecieved) begin
            ackArmed <= 1'b1;
         end else if (ackTaken) begin
            ackArmed <= 1'b0;
         end

         case (state)
            EMPTY: begin
               if (commitNow) begin
                  presentBank <= fillNext;
                  fillBank    <= '0;
                  pending     <= 1'b0;
                  state       <= PRESENT;
               end else begin
                  fillBank <= fillNext;
               end
            end
            PRESENT: begin
               fillBank <= fillNext;
               if (layerDone && !pending) begin
                  pending <= 1'b1;
               end
               if (ackTaken) begin
                  state      <= RELEASE;
                  layersSent <= layersSent + 8'd1;
               end
            end
            RELEASE: begin
               fillBank <= fillNext;
               if (layerDone && !pending) begin
                  pending <= 1'b1;
               end
               if (!inputsRecieved) begin
                  state <= EMPTY;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_relu_output_stager.sv
// Bench for relu_output_stager with 4 slots of 8 bits.
// Stimulus pushes each expected presented layer into a queue; a monitor pops on every rising outputsReady.
// Directed checks cover reset, latency, busy/pending, four-phase hold, reset priority and counter wrap.

module tb_relu_output_stager;

   logic        clk = 1'b0;
   logic        reset;
   logic        nodeWriteEnable;
   logic [2:0]  nodeIndex;
   logic [7:0]  nodeValue;
   logic        layerDone;
   logic        stagerBusy;
   logic        outputsReady;
   logic        inputsRecieved;
   logic [31:0] layer2Input;
   logic [7:0]  layersSent;

   int checks   = 0;
   int failures = 0;

   logic [31:0] expQ[$];
   logic        prevReady = 1'b0;
   logic [31:0] heldData  = 32'd0;

   always #5 clk = ~clk;

   relu_output_stager #(
      .RELU_NODES (4),
      .VALUE_WIDTH(8),
      .INDEX_WIDTH(3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .nodeWriteEnable(nodeWriteEnable),
      .nodeIndex      (nodeIndex),
      .nodeValue      (nodeValue),
      .layerDone      (layerDone),
      .stagerBusy     (stagerBusy),
      .outputsReady   (outputsReady),
      .inputsRecieved (inputsRecieved),
      .layer2Input    (layer2Input),
      .layersSent     (layersSent)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [7:0] val);
      nodeWriteEnable = 1'b1;
      nodeIndex       = idx;
      nodeValue       = val;
      step();
      nodeWriteEnable = 1'b0;
   endtask

   // Monitor: compare each new presentation against the scoreboard, and hold-stability while presented.
   always @(negedge clk) begin
      if (outputsReady && !prevReady) begin
         if (expQ.size() == 0) begin
            check("unexpected_presentation", layer2Input, 32'hxxxxxxxx);
         end else begin
            check("presented_layer", layer2Input, expQ.pop_front());
         end
         heldData = layer2Input;
      end else if (outputsReady && prevReady) begin
         check("present_stable", layer2Input, heldData);
      end
      prevReady = outputsReady;
   end

   // Watchdog so the bench always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; nodeWriteEnable = 1'b0; nodeIndex = 3'd0; nodeValue = 8'd0;
      layerDone = 1'b0; inputsRecieved = 1'b0;
      step(); step();
      check("rst_ready",  {31'd0, outputsReady}, 32'd0);
      check("rst_busy",   {31'd0, stagerBusy},   32'd0);
      check("rst_sent",   {24'd0, layersSent},   32'd0);
      check("rst_data",   layer2Input,           32'd0);
      reset = 1'b0;
      step();

      // Basic layer.
      wr(3'd0, 8'h11); wr(3'd1, 8'h22); wr(3'd2, 8'h33); wr(3'd3, 8'h44);
      expQ.push_back(32'h44332211);
      layerDone = 1'b1; step(); layerDone = 1'b0;
      check("basic_ready", {31'd0, outputsReady}, 32'd1);
      inputsRecieved = 1'b1; step();
      check("basic_ack_ready", {31'd0, outputsReady}, 32'd0);
      check("basic_sent", {24'd0, layersSent}, 32'd1);
      inputsRecieved = 1'b0; step();
      check("basic_release_ready", {31'd0, outputsReady}, 32'd0);

      // Partial layer, out-of-range slot, write coincident with layerDone.
      wr(3'd2, 8'h7F); wr(3'd5, 8'hAA);
      expQ.push_back(32'h007F0001);
      nodeWriteEnable = 1'b1; nodeIndex = 3'd0; nodeValue = 8'h01; layerDone = 1'b1;
      step();
      nodeWriteEnable = 1'b0; layerDone = 1'b0;
      check("partial_ready", {31'd0, outputsReady}, 32'd1);

      // Overlap: fill layer B while presenting, duplicate write, commit goes pending.
      wr(3'd1, 8'h55); wr(3'd1, 8'h66); wr(3'd3, 8'h99);
      layerDone = 1'b1; step(); layerDone = 1'b0;
      check("overlap_busy", {31'd0, stagerBusy}, 32'd1);
      check("overlap_hold", layer2Input, 32'h007F0001);
      wr(3'd0, 8'hEE);
      expQ.push_back(32'h99006600);
      inputsRecieved = 1'b1; step();
      check("overlap_ack_ready", {31'd0, outputsReady}, 32'd0);
      check("overlap_sent", {24'd0, layersSent}, 32'd2);

      // Four-phase: ack held high keeps outputsReady low despite the pending commit.
      for (int i = 0; i < 5; i++) begin
         step();
         check("fourphase_ready_low", {31'd0, outputsReady}, 32'd0);
         check("fourphase_busy", {31'd0, stagerBusy}, 32'd1);
      end
      inputsRecieved = 1'b0; step();
      check("empty_ready_low", {31'd0, outputsReady}, 32'd0);
      step();
      check("pending_ready", {31'd0, outputsReady}, 32'd1);
      check("pending_busy_clear", {31'd0, stagerBusy}, 32'd0);
      check("pending_data", layer2Input, 32'h99006600);
      inputsRecieved = 1'b1; step();
      inputsRecieved = 1'b0; step();
      check("sent_three", {24'd0, layersSent}, 32'd3);

      // Reset while presenting with coincident layerDone; ack left high across reset.
      wr(3'd0, 8'h12);
      expQ.push_back(32'h00000012);
      layerDone = 1'b1; step();
      check("prereset_ready", {31'd0, outputsReady}, 32'd1);
      reset = 1'b1; inputsRecieved = 1'b1; step();
      reset = 1'b0; layerDone = 1'b0;
      check("reset_ready", {31'd0, outputsReady}, 32'd0);
      check("reset_busy",  {31'd0, stagerBusy},   32'd0);
      check("reset_data",  layer2Input,           32'd0);
      check("reset_sent",  {24'd0, layersSent},   32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("reset_no_present", {31'd0, outputsReady}, 32'd0);
      end

      // Stale ack from before reset must not retire the next layer.
      wr(3'd3, 8'hC3);
      expQ.push_back(32'hC3000000);
      layerDone = 1'b1; step(); layerDone = 1'b0;
      step(); step();
      check("stale_ack_ready", {31'd0, outputsReady}, 32'd1);
      check("stale_ack_sent", {24'd0, layersSent}, 32'd0);
      inputsRecieved = 1'b0; step();
      inputsRecieved = 1'b1; step();
      check("fresh_ack_sent", {24'd0, layersSent}, 32'd1);
      inputsRecieved = 1'b0; step();

      // Wrap: 256 handshakes from reset.
      reset = 1'b1; step(); reset = 1'b0; step();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = i[7:0];
         expQ.push_back({24'd0, v});
         nodeWriteEnable = 1'b1; nodeIndex = 3'd0; nodeValue = v; layerDone = 1'b1;
         step();
         nodeWriteEnable = 1'b0; layerDone = 1'b0;
         inputsRecieved = 1'b1; step();
         inputsRecieved = 1'b0; step();
         if (i == 254) check("wrap_255", {24'd0, layersSent}, 32'd255);
      end
      check("wrap_zero", {24'd0, layersSent}, 32'd0);
      step();
      check("scoreboard_drained", expQ.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
